// File: rtl/clock_step_controller_pkg.sv
// -----------------------------------------------------------------------------
// clock_step_controller_pkg
// Shared definitions for the clock step controller:
//   - datapath widths (divisor and tick counter)
//   - FSM state encodings, kept as plain localparam constants so the encoding
//     seen on state_out is fixed and stable
//   - helpers to clamp a requested divisor and to classify counting states
// -----------------------------------------------------------------------------
package clock_step_controller_pkg;

  localparam int DIVISOR_W  = 28;
  localparam int TICK_CNT_W = 16;
  localparam int STATE_W    = 3;

  localparam logic [STATE_W-1:0] ST_HALT      = 3'd0;
  localparam logic [STATE_W-1:0] ST_RUN       = 3'd1;
  localparam logic [STATE_W-1:0] ST_DRAIN     = 3'd2;
  localparam logic [STATE_W-1:0] ST_STEP      = 3'd3;
  localparam logic [STATE_W-1:0] ST_STEP_HOLD = 3'd4;

  // Raise a requested divisor to the smallest supported period.
  function automatic logic [DIVISOR_W-1:0] clamp_divisor(
    input logic [DIVISOR_W-1:0] value,
    input logic [DIVISOR_W-1:0] min_value
  );
    logic [DIVISOR_W-1:0] result;
    if (value < min_value) begin
      result = min_value;
    end else begin
      result = value;
    end
    return result;
  endfunction

  // States in which the period counter advances and ticks may be issued.
  function automatic logic is_counting_state(input logic [STATE_W-1:0] state);
    logic result;
    case (state)
      ST_RUN, ST_DRAIN, ST_STEP: result = 1'b1;
      default:                   result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/clock_step_controller_counter.sv
// -----------------------------------------------------------------------------
// clock_period_counter
// Period counter used by clock_step_controller. While enabled it counts
// 0 .. divisor-1 and wraps; while disabled it is held at zero so every new
// RUN/STEP entry starts a full period.
//
// Ports:
//   clock_in     system clock, rising edge
//   reset        synchronous active-high reset
//   i_enable     high while the controller is in a counting state
//   i_divisor    period length in clock_in cycles
//   o_count      current position inside the period
//   o_wrap       high in the last cycle of a period (only while enabled)
//   o_clock_out  divided square wave: high in the upper half of the period
// -----------------------------------------------------------------------------
module clock_period_counter
  import clock_step_controller_pkg::*;
(
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 i_enable,
  input  logic [DIVISOR_W-1:0] i_divisor,
  output logic [DIVISOR_W-1:0] o_count,
  output logic                 o_wrap,
  output logic                 o_clock_out
);

  logic [DIVISOR_W-1:0] r_count;
  logic [DIVISOR_W-1:0] w_last;
  logic [DIVISOR_W-1:0] w_half;
  logic                 w_at_last;

  assign w_last = i_divisor - 28'd1;
  assign w_half = {1'b0, i_divisor[DIVISOR_W-1:1]};

  // '>=' rather than '==' so a corrupted count beyond the period still
  // recovers at the next edge instead of running through the full range.
  assign w_at_last = (r_count >= w_last);

  // Period position: advance while enabled, wrap after the last cycle.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_count <= 28'd0;
    end else if (!i_enable) begin
      r_count <= 28'd0;
    end else if (w_at_last) begin
      r_count <= 28'd0;
    end else begin
      r_count <= r_count + 28'd1;
    end
  end

  // Output decode from the count register and the enable (itself a register
  // decode in the parent), so nothing here depends on a primary input.
  always_comb begin
    o_count     = r_count;
    o_wrap      = 1'b0;
    o_clock_out = 1'b0;
    if (i_enable) begin
      o_wrap      = w_at_last;
      o_clock_out = (r_count >= w_half);
    end else begin
      o_wrap      = 1'b0;
      o_clock_out = 1'b0;
    end
  end

endmodule

// File: rtl/clock_step_controller.sv
// -----------------------------------------------------------------------------
// clock_step_controller
// Produces a one-cycle tick enable and a divided square wave from clock_in.
// Ticks can free-run (run_req level) or be single-stepped (one tick per
// rising edge of step_req). The divisor can be changed at run time; a new
// value is held pending and only takes effect on a period boundary or while
// halted, so no period is ever truncated or stretched.
//
// Ports:
//   clock_in    system clock, rising edge
//   reset       synchronous active-high reset
//   run_req     level, request free-running ticks
//   step_req    level, each rising edge requests one tick
//   div_load    one-cycle strobe capturing div_value as pending divisor
//   div_value   requested divisor (clock_in cycles per tick)
//   tick_out    one-cycle pulse per completed period
//   clock_out   divided square wave
//   state_out   current FSM state encoding
//   busy        high in every state except HALT
//   div_active  divisor currently in use
//   tick_count  ticks issued since reset (wrapping)
// -----------------------------------------------------------------------------
module clock_step_controller
  import clock_step_controller_pkg::*;
#(
  parameter logic [DIVISOR_W-1:0] DEFAULT_DIVISOR = 28'd50000000,
  parameter logic [DIVISOR_W-1:0] MIN_DIVISOR     = 28'd2
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic                  run_req,
  input  logic                  step_req,
  input  logic                  div_load,
  input  logic [DIVISOR_W-1:0]  div_value,
  output logic                  tick_out,
  output logic                  clock_out,
  output logic [STATE_W-1:0]    state_out,
  output logic                  busy,
  output logic [DIVISOR_W-1:0]  div_active,
  output logic [TICK_CNT_W-1:0] tick_count
);

  localparam logic [DIVISOR_W-1:0] RESET_DIVISOR =
    clamp_divisor(DEFAULT_DIVISOR, MIN_DIVISOR);

  logic [STATE_W-1:0]    r_state;
  logic [STATE_W-1:0]    w_state_next;
  logic                  r_step_q;
  logic                  w_step_rise;
  logic [DIVISOR_W-1:0]  r_div_active;
  logic [DIVISOR_W-1:0]  r_div_pending;
  logic                  r_pending_valid;
  logic [TICK_CNT_W-1:0] r_tick_count;
  logic                  w_counting;
  logic                  w_wrap;
  logic                  w_clock_out;
  logic                  w_commit;
  logic [DIVISOR_W-1:0]  w_count;

  assign w_step_rise = step_req & ~r_step_q;
  assign w_counting  = is_counting_state(r_state);

  // w_wrap is already gated by the counting states, so it is the tick itself.
  // Commit points: any HALT cycle, or the last cycle of a period.
  assign w_commit = (r_state == ST_HALT) | w_wrap;

  clock_period_counter u_period (
    .clock_in    (clock_in),
    .reset       (reset),
    .i_enable    (w_counting),
    .i_divisor   (r_div_active),
    .o_count     (w_count),
    .o_wrap      (w_wrap),
    .o_clock_out (w_clock_out)
  );

  // Registered copy of step_req for rising-edge detection.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_step_q <= 1'b0;
    end else begin
      r_step_q <= step_req;
    end
  end

  // Next-state logic. In DRAIN a returning run_req wins over the final wrap
  // so a quick re-request keeps ticking without a HALT gap.
  always_comb begin
    w_state_next = ST_HALT;
    case (r_state)
      ST_HALT: begin
        if (run_req) begin
          w_state_next = ST_RUN;
        end else if (w_step_rise) begin
          w_state_next = ST_STEP;
        end else begin
          w_state_next = ST_HALT;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (run_req) begin
          w_state_next = ST_RUN;
        end else if (w_wrap) begin
          w_state_next = ST_HALT;
        end else begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_STEP: begin
        // run_req and further step edges are ignored until the step completes.
        if (w_wrap) begin
          w_state_next = ST_STEP_HOLD;
        end else begin
          w_state_next = ST_STEP;
        end
      end
      ST_STEP_HOLD: begin
        // Wait for release so a held button yields only one step.
        if (step_req) begin
          w_state_next = ST_STEP_HOLD;
        end else begin
          w_state_next = ST_HALT;
        end
      end
      default: begin
        w_state_next = ST_HALT;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_state <= ST_HALT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Active divisor: takes the pending value only at a commit point.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_div_active <= RESET_DIVISOR;
    end else if (w_commit && r_pending_valid) begin
      r_div_active <= r_div_pending;
    end else begin
      r_div_active <= r_div_active;
    end
  end

  // Pending divisor. A load on a commit cycle is kept for the next commit
  // point (the old pending value is the one committed this cycle).
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_div_pending   <= RESET_DIVISOR;
      r_pending_valid <= 1'b0;
    end else if (div_load) begin
      r_div_pending   <= clamp_divisor(div_value, MIN_DIVISOR);
      r_pending_valid <= 1'b1;
    end else if (w_commit) begin
      r_div_pending   <= r_div_pending;
      r_pending_valid <= 1'b0;
    end else begin
      r_div_pending   <= r_div_pending;
      r_pending_valid <= r_pending_valid;
    end
  end

  // Tick counter, wraps naturally at its width.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_tick_count <= 16'd0;
    end else if (w_wrap) begin
      r_tick_count <= r_tick_count + 16'd1;
    end else begin
      r_tick_count <= r_tick_count;
    end
  end

  assign tick_out   = w_wrap;
  assign clock_out  = w_clock_out;
  assign state_out  = r_state;
  assign busy       = (r_state != ST_HALT);
  assign div_active = r_div_active;
  assign tick_count = r_tick_count;

  // The raw count is only observed through wrap/clock_out decode here.
  logic w_unused_count;
  assign w_unused_count = ^w_count;

endmodule

// File: tb/tb_clock_step_controller.sv
// -----------------------------------------------------------------------------
// tb_clock_step_controller
// Directed scenarios plus randomized stimulus, all compared cycle by cycle
// against a behavioural model of the controller, plus scenario-specific
// constant expectations.
// -----------------------------------------------------------------------------
module tb_clock_step_controller;

  localparam logic [27:0] DEF_DIV = 28'd50000000;

  logic        clock_in = 1'b0;
  logic        reset;
  logic        run_req;
  logic        step_req;
  logic        div_load;
  logic [27:0] div_value;
  logic        tick_out;
  logic        clock_out;
  logic [2:0]  state_out;
  logic        busy;
  logic [27:0] div_active;
  logic [15:0] tick_count;

  clock_step_controller #(
    .DEFAULT_DIVISOR (DEF_DIV),
    .MIN_DIVISOR     (28'd2)
  ) dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .run_req    (run_req),
    .step_req   (step_req),
    .div_load   (div_load),
    .div_value  (div_value),
    .tick_out   (tick_out),
    .clock_out  (clock_out),
    .state_out  (state_out),
    .busy       (busy),
    .div_active (div_active),
    .tick_count (tick_count)
  );

  always #5 clock_in = ~clock_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: mode (0 idle,1 run,2 drain,3 step,4 hold), position
  // inside the current period, divisor in use, pending divisor, tick total.
  int m_mode, m_pos, m_div, m_pend, m_ticks;
  bit m_pend_v, m_prev_step;

  localparam logic [49:0] RESET_VEC = {1'b0, 1'b0, 1'b0, 3'd0, DEF_DIV, 16'd0};

  function automatic logic [49:0] dut_vec();
    return {tick_out, clock_out, busy, state_out, div_active, tick_count};
  endfunction

  function automatic logic [49:0] exp_vec();
    logic act, tk, ck, bz;
    logic [2:0]  s;
    logic [27:0] d;
    logic [15:0] t;
    act = (m_mode >= 1) && (m_mode <= 3);
    tk  = act && (m_pos == m_div - 1);
    ck  = act && (m_pos >= m_div / 2);
    bz  = (m_mode != 0);
    s   = m_mode[2:0];
    d   = m_div[27:0];
    t   = m_ticks[15:0];
    return {tk, ck, bz, s, d, t};
  endfunction

  task automatic model_update(input bit rst, input bit run, input bit step,
                              input bit load, input int val);
    bit act, tk, rise, commit;
    int nxt;
    if (rst) begin
      m_mode = 0; m_pos = 0; m_div = int'(DEF_DIV); m_pend = 0;
      m_pend_v = 1'b0; m_prev_step = 1'b0; m_ticks = 0;
      return;
    end
    act  = (m_mode >= 1) && (m_mode <= 3);
    tk   = act && (m_pos == m_div - 1);
    rise = step && !m_prev_step;
    case (m_mode)
      0:       nxt = run ? 1 : (rise ? 3 : 0);
      1, 2:    nxt = run ? 1 : (tk ? 0 : 2);
      3:       nxt = tk ? 4 : 3;
      default: nxt = step ? 4 : 0;
    endcase
    commit = (m_mode == 0) || tk;
    if (commit && m_pend_v) m_div = m_pend;
    if (load) begin
      m_pend   = (val < 2) ? 2 : val;
      m_pend_v = 1'b1;
    end else if (commit) begin
      m_pend_v = 1'b0;
    end
    m_pos = (act && !tk) ? m_pos + 1 : 0;
    if (tk) m_ticks = (m_ticks + 1) % 65536;
    m_prev_step = step;
    m_mode = nxt;
  endtask

  task automatic drive(input bit rst, input bit run, input bit step,
                       input bit load, input int val);
    reset = rst; run_req = run; step_req = step; div_load = load;
    div_value = val[27:0];
  endtask

  // Update the model with the inputs presented this cycle, then step the clock.
  task automatic advance();
    model_update(reset, run_req, step_req, div_load, int'(div_value));
    @(posedge clock_in);
    #1;
  endtask

  task automatic load_and_commit(input int val);
    drive(1'b0, 1'b0, 1'b0, 1'b1, val); advance();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0);   advance();
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0); advance();
    #2;
    n_checks++;
    if (dut_vec() !== RESET_VEC) begin
      n_fail++; $display("FAIL reset_hold got=%h exp=%h", dut_vec(), RESET_VEC);
    end
    advance();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0); advance();
    #2;
    n_checks++;
    if (dut_vec() !== RESET_VEC) begin
      n_fail++; $display("FAIL reset_after got=%h exp=%h", dut_vec(), RESET_VEC);
    end
  endtask

  task automatic test_run_div5();
    int ticks, highs, last, bad_gap, first;
    ticks = 0; highs = 0; last = -1; bad_gap = 0; first = -1;
    load_and_commit(5);
    #2;
    n_checks++;
    if (div_active !== 28'd5) begin
      n_fail++; $display("FAIL run5_div got=%0d exp=5", div_active);
    end
    for (int i = 0; i < 35; i++) begin
      drive(1'b0, i < 30, 1'b0, 1'b0, 0);
      #2;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL run5_cyc%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (tick_out === 1'b1) begin
        if (first < 0) first = i;
        if (last >= 0 && (i - last) != 5) bad_gap++;
        last = i; ticks++;
      end
      if (clock_out === 1'b1) highs++;
      advance();
    end
    #2;
    n_checks++;
    if (ticks != 6 || first != 5 || bad_gap != 0) begin
      n_fail++; $display("FAIL run5_ticks got=%0d first=%0d gaps=%0d exp=6/5/0", ticks, first, bad_gap);
    end
    n_checks++;
    if (highs != 18) begin
      n_fail++; $display("FAIL run5_high got=%0d exp=18", highs);
    end
    n_checks++;
    if (tick_count !== 16'd6 || busy !== 1'b0) begin
      n_fail++; $display("FAIL run5_count got=%0d busy=%b exp=6/0", tick_count, busy);
    end
  endtask

  task automatic test_drain();
    int ticks, tick_at;
    logic [2:0] st5;
    logic bz9;
    ticks = 0; tick_at = -1; st5 = 3'd7; bz9 = 1'b1;
    load_and_commit(8);
    for (int i = 0; i < 13; i++) begin
      // RUN from cycle 1, counter = i-1; run_req dropped while counter is 3.
      drive(1'b0, i < 4, 1'b0, 1'b0, 0);
      #2;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL drain_cyc%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (tick_out === 1'b1) begin ticks++; tick_at = i; end
      if (i == 5) st5 = state_out;
      if (i == 9) bz9 = busy;
      advance();
    end
    n_checks++;
    if (st5 !== 3'd2) begin
      n_fail++; $display("FAIL drain_state got=%0d exp=2", st5);
    end
    n_checks++;
    if (ticks != 1 || tick_at != 8 || bz9 !== 1'b0) begin
      n_fail++; $display("FAIL drain_tick got=%0d at=%0d busy=%b exp=1/8/0", ticks, tick_at, bz9);
    end
  endtask

  task automatic test_step_hold();
    int ticks, tick_at;
    logic [2:0] st25, st40, st41;
    ticks = 0; tick_at = -1; st25 = 3'd7; st40 = 3'd7; st41 = 3'd7;
    load_and_commit(10);
    for (int i = 0; i < 45; i++) begin
      drive(1'b0, 1'b0, i < 40, 1'b0, 0);
      #2;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL step_cyc%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (tick_out === 1'b1) begin ticks++; tick_at = i; end
      if (i == 25) st25 = state_out;
      if (i == 40) st40 = state_out;
      if (i == 41) st41 = state_out;
      advance();
    end
    n_checks++;
    if (ticks != 1 || tick_at != 10) begin
      n_fail++; $display("FAIL step_tick got=%0d at=%0d exp=1/10", ticks, tick_at);
    end
    n_checks++;
    if (st25 !== 3'd4 || st40 !== 3'd4 || st41 !== 3'd0) begin
      n_fail++; $display("FAIL step_hold got=%0d/%0d/%0d exp=4/4/0", st25, st40, st41);
    end
  endtask

  task automatic test_div_change();
    int tq[$];
    int exp_t[5] = '{6, 10, 14, 18, 22};
    int bad;
    bad = 0;
    load_and_commit(6);
    for (int i = 0; i < 28; i++) begin
      // New divisor loaded while counter = 2 of the first 6-cycle period.
      drive(1'b0, i < 22, 1'b0, i == 3, 4);
      #2;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL divchg_cyc%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (tick_out === 1'b1) tq.push_back(i);
      advance();
    end
    if (tq.size() != 5) bad = 1;
    else for (int k = 0; k < 5; k++) if (tq[k] != exp_t[k]) bad = 1;
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL divchg_ticks got=%p exp=%p", tq, exp_t);
    end
    load_and_commit(1);
    #2;
    n_checks++;
    if (div_active !== 28'd2) begin
      n_fail++; $display("FAIL clamp got=%0d exp=2", div_active);
    end
  endtask

  task automatic test_priority_reset();
    int ticks;
    logic [2:0] st1;
    ticks = 0; st1 = 3'd7;
    load_and_commit(8);
    for (int i = 0; i < 5; i++) begin
      // Cycle 0: run_req and step rise together; reset while counter = 3.
      drive(i == 4, 1'b1, 1'b1, 1'b0, 0);
      #2;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL prio_cyc%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (tick_out === 1'b1) ticks++;
      if (i == 1) st1 = state_out;
      advance();
    end
    #2;
    n_checks++;
    if (st1 !== 3'd1 || ticks != 0) begin
      n_fail++; $display("FAIL prio_run got=%0d ticks=%0d exp=1/0", st1, ticks);
    end
    n_checks++;
    if (dut_vec() !== RESET_VEC) begin
      n_fail++; $display("FAIL midreset got=%h exp=%h", dut_vec(), RESET_VEC);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0); advance();
    #2;
    n_checks++;
    if (dut_vec() !== RESET_VEC) begin
      n_fail++; $display("FAIL midreset_after got=%h exp=%h", dut_vec(), RESET_VEC);
    end
  endtask

  task automatic test_random();
    bit run, step, rst, load;
    int val, shown;
    run = 1'b0; step = 1'b0; shown = 0;
    for (int i = 0; i < 2500; i++) begin
      rst  = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 19) == 0) run = ~run;
      if ($urandom_range(0, 7) == 0) step = ~step;
      load = ($urandom_range(0, 11) == 0);
      val  = int'($urandom_range(0, 9));
      drive(rst, run, step, load, val);
      #2;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        if (shown < 10) begin
          shown++;
          $display("FAIL rand_cyc%0d got=%h exp=%h", i, dut_vec(), exp_vec());
        end
      end
      advance();
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
    test_reset();
    test_run_div5();
    test_drain();
    test_step_hold();
    test_div_change();
    test_priority_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
